gamepad_controller: RTL and testbench

- Serial reader for an NES-style 8-button gamepad (shift-register pad: latch, clock, data lines).
- Periodically strobes GLatch, clocks out 8 bits with GPulse, and samples GamePadData.
- Presents a stable active-high 8-bit button vector on GamePad to the CPU and to the debug LEDs.
- Runs on the 25 MHz system clock derived in the top level.

---
 rtl/gamepad_pkg.sv | 28 ++
 rtl/gamepad_tick_gen.sv | 30 +++
 rtl/gamepad_controller.sv | 141 ++++++++++++++
 tb/tb_gamepad_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/gamepad_pkg.sv
// Shared types and constants for the NES-style serial gamepad reader.
package gamepad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } gp_state_e;

    localparam int NUM_BUTTONS = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // 6 us tick, 12 us latch, ~60 Hz poll at 25 MHz
    localparam int DEF_TICK_CYCLES = 150;
    localparam int DEF_LATCH_TICKS = 2;
    localparam int DEF_POLL_TICKS  = 2778;

endpackage

// File: rtl/gamepad_tick_gen.sv
// Free-running protocol tick: one-cycle pulse every TICK_CYCLES clocks.
module gamepad_tick_gen
    import gamepad_pkg::*;
#(
    parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
    input  logic Clock,
    input  logic Reset,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(TICK_CYCLES - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gamepad_controller.sv
// Polls an NES shift-register pad and publishes an active-high button vector.
//   state | meaning
//   IDLE  | waiting for the poll period to elapse
//   LATCH | GLatch high, pad loads its buttons
//   LOW   | GPulse low, sample current bit on closing tick
//   HIGH  | GPulse high, pad shifts to next bit
//   DONE  | shadow copied to GamePad, back to IDLE
module gamepad_controller
    import gamepad_pkg::*;
#(
    parameter int TICK_CYCLES = DEF_TICK_CYCLES,
    parameter int LATCH_TICKS = DEF_LATCH_TICKS,
    parameter int POLL_TICKS  = DEF_POLL_TICKS
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   GamePadData,
    output logic [NUM_BUTTONS-1:0] GamePad,
    output logic                   GPulse,
    output logic                   GLatch
);

    localparam int PW = $clog2(POLL_TICKS + 1);
    localparam int LW = $clog2(LATCH_TICKS + 1);

    logic tick;

    logic                   sync1_q, sync2_q;
    gp_state_e              state_q, state_d;
    logic [PW-1:0]          poll_cnt_q, poll_cnt_d;
    logic [LW-1:0]          latch_cnt_q, latch_cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [NUM_BUTTONS-1:0] shadow_q, shadow_d;
    logic [NUM_BUTTONS-1:0] gamepad_q, gamepad_d;
    logic                   glatch_q, glatch_d;
    logic                   gpulse_q, gpulse_d;
    logic                   polled_q, polled_d;

    gamepad_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .Clock(Clock),
        .Reset(Reset),
        .tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        poll_cnt_d  = poll_cnt_q;
        latch_cnt_d = latch_cnt_q;
        bit_idx_d   = bit_idx_q;
        shadow_d    = shadow_q;
        gamepad_d   = gamepad_q;
        polled_d    = polled_q;

        // Saturating so a long stall can never alias into an early poll
        if (tick && (poll_cnt_q < PW'(POLL_TICKS))) begin
            poll_cnt_d = poll_cnt_q + PW'(1);
        end

        case (state_q)
            IDLE: begin
                if (tick && (!polled_q || (poll_cnt_q >= PW'(POLL_TICKS - 1)))) begin
                    state_d     = LATCH;
                    poll_cnt_d  = '0;
                    latch_cnt_d = '0;
                    polled_d    = 1'b1;
                end
            end
            LATCH: begin
                if (tick) begin
                    if (latch_cnt_q == LW'(LATCH_TICKS - 1)) begin
                        state_d   = LOW;
                        bit_idx_d = 3'd0;
                    end else begin
                        latch_cnt_d = latch_cnt_q + LW'(1);
                    end
                end
            end
            LOW: begin
                if (tick) begin
                    shadow_d[bit_idx_q] = ~sync2_q;
                    state_d             = HIGH;
                end
            end
            HIGH: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d   = DONE;
                        gamepad_d = shadow_q;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        state_d   = LOW;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        glatch_d = (state_d == LATCH);
        gpulse_d = (state_d == HIGH);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= IDLE;
            poll_cnt_q  <= '0;
            latch_cnt_q <= '0;
            bit_idx_q   <= '0;
            shadow_q    <= '0;
            gamepad_q   <= '0;
            glatch_q    <= 1'b0;
            gpulse_q    <= 1'b0;
            polled_q    <= 1'b0;
        end else begin
            sync1_q     <= GamePadData;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            poll_cnt_q  <= poll_cnt_d;
            latch_cnt_q <= latch_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shadow_q    <= shadow_d;
            gamepad_q   <= gamepad_d;
            glatch_q    <= glatch_d;
            gpulse_q    <= gpulse_d;
            polled_q    <= polled_d;
        end
    end

    assign GamePad = gamepad_q;
    assign GLatch  = glatch_q;
    assign GPulse  = gpulse_q;

endmodule

// File: tb/tb_gamepad_controller.sv
// Bench for gamepad_controller: shift-register pad model plus a timeline reference.
module tb_gamepad_controller;

    localparam int T   = 4;
    localparam int L   = 2;
    localparam int P   = 24;
    localparam int UPD = (L + 16) * T;
    localparam int NV  = 9;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       GamePadData = 1'b1;
    logic [7:0] GamePad;
    logic       GPulse;
    logic       GLatch;

    gamepad_controller #(
        .TICK_CYCLES(T),
        .LATCH_TICKS(L),
        .POLL_TICKS (P)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .GamePadData(GamePadData),
        .GamePad    (GamePad),
        .GPulse     (GPulse),
        .GLatch     (GLatch)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    int n = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, n);
        end
    endtask

    function automatic int rel_of(input int nn);
        if (nn < T) return -1;
        return (nn - T) % (P * T);
    endfunction

    // Pad: 0 = shift register with pattern, 1 = data held low, 2 = held high, 3 = noise
    int         mode = 3;
    logic [7:0] pat = 8'h00;
    logic [7:0] pad_sr = 8'h00;
    int         pad_bit = 0;
    logic       pad_prev = 1'b0;

    always @(negedge Clock) begin
        if (GLatch) begin
            pad_sr  = pat;
            pad_bit = 0;
        end else if (GPulse && !pad_prev) begin
            pad_bit++;
        end
        pad_prev = GPulse;
        case (mode)
            0:       GamePadData = (pad_bit < 8) ? ~pad_sr[pad_bit] : 1'b1;
            1:       GamePadData = 1'b0;
            2:       GamePadData = 1'b1;
            default: GamePadData = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference: scans start every P ticks from tick 1; result is the button set at latch time
    logic [7:0] gp_exp = 8'h00;
    logic [7:0] scan_val = 8'h00;

    always @(posedge Clock) begin
        if (!Reset) begin
            n      = 0;
            gp_exp = 8'h00;
        end else begin
            n++;
            if (rel_of(n) == 0)
                scan_val = (mode == 1) ? 8'hFF : (mode == 2) ? 8'h00 : pat;
            if (rel_of(n) == UPD)
                gp_exp = scan_val;
        end
    end

    logic prev_l = 1'b0;
    logic prev_p = 1'b0;
    int   last_rise = -1;
    int   pulses = 0;
    int   r, o;
    logic el, ep;

    always @(negedge Clock) begin
        if (!Reset) begin
            check("rst_glatch", {7'b0, GLatch}, 8'h00);
            check("rst_gpulse", {7'b0, GPulse}, 8'h00);
            check("rst_gamepad", GamePad, 8'h00);
            prev_l    = 1'b0;
            prev_p    = 1'b0;
            last_rise = -1;
            pulses    = 0;
        end else begin
            r  = rel_of(n);
            o  = r - L * T;
            el = (r >= 0) && (r < L * T);
            ep = (r >= 0) && (o >= T) && (o < 16 * T) && (((o / T) % 2) == 1);
            check("glatch", {7'b0, GLatch}, {7'b0, el});
            check("gpulse", {7'b0, GPulse}, {7'b0, ep});
            check("gamepad", GamePad, gp_exp);
            if (GLatch && !prev_l) begin
                if (last_rise < 0) begin
                    check_int("first_latch_cycle", n, T);
                end else begin
                    check_int("latch_spacing", n - last_rise, P * T);
                    check_int("pulses_per_scan", pulses, 8);
                end
                last_rise = n;
                pulses    = 0;
            end
            if (GPulse && !prev_p) pulses++;
            prev_l = GLatch;
            prev_p = GPulse;
        end
    end

    task automatic wait_rel(input int target);
        for (int k = 0; k < 2 * P * T; k++) begin
            @(negedge Clock);
            if (Reset && (rel_of(n) == target)) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_rel: scan offset %0d not reached, got cycle %0d", target, n);
    endtask

    typedef struct {
        int         mode;
        logic [7:0] pat;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[NV];
    logic [7:0] old_val;

    initial begin
        vecs[0] = '{0, 8'h01, 8'h01};
        vecs[1] = '{0, 8'h48, 8'h48};
        vecs[2] = '{1, 8'h00, 8'hFF};
        vecs[3] = '{2, 8'hFF, 8'h00};
        vecs[4] = '{0, 8'hA5, 8'hA5};
        for (int i = 5; i < NV; i++) begin
            vecs[i].mode = 0;
            vecs[i].pat  = 8'($urandom_range(2, 254));
            vecs[i].exp  = vecs[i].pat;
        end

        #1 Reset = 1'b0;
        mode = 3;
        repeat (10) @(posedge Clock);
        #2;
        mode  = vecs[0].mode;
        pat   = vecs[0].pat;
        Reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            wait_rel(UPD);
            check("vector", GamePad, vecs[i].exp);
            if (i + 1 < NV) begin
                mode = vecs[i + 1].mode;
                pat  = vecs[i + 1].pat;
            end
        end

        old_val = vecs[NV - 1].exp;
        mode = 0;
        pat  = 8'h01;
        wait_rel(L * T + 3 * T);
        pat = 8'h80;
        wait_rel(UPD - 1);
        check("mid_change_hold", GamePad, old_val);
        wait_rel(UPD);
        check("mid_change_scan", GamePad, 8'h01);
        wait_rel(UPD);
        check("mid_change_next", GamePad, 8'h80);

        wait_rel(L * T + 8 * T + 1);
        @(posedge Clock);
        #2 Reset = 1'b0;
        #1;
        check("midscan_rst_gamepad", GamePad, 8'h00);
        check("midscan_rst_glatch", {7'b0, GLatch}, 8'h00);
        check("midscan_rst_gpulse", {7'b0, GPulse}, 8'h00);
        repeat (3) @(posedge Clock);
        #2 Reset = 1'b1;
        wait_rel(UPD);
        check("post_rst_scan", GamePad, 8'h80);

        repeat (5) @(negedge Clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
